fp_div_d: RTL and testbench
===========================

// Module: fp_div_d
// PURPOSE
//  Iterative IEEE 754 double-precision divider (result = a / b), round-to-nearest-even.
//  Inverse companion to the combinational double multiplier in the D-extension ALU.
//  Shares the multiplier's number-format rules: subnormal handling, canonical NaN, and overflow/underflow policy.
//  One radix-2 restoring quotient bit per cycle, behind a valid/ready handshake on each side.
// PARAMETERS
//  QBITS  55  quotient bits generated: 53 significand + guard + 1 normalisation bit; not to be overridden
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operands a/b valid
//  in_ready   out  1   block idle, can accept operands (state==IDLE)
//  a          in   64  dividend (double)
//  b          in   64  divisor (double)
//  out_valid  out  1   result valid; held until out_ready
//  out_ready  in   1   consumer accepts result
//  result     out  64  quotient (double)
//  flag_nv    out  1   invalid operation (NaN operand, 0/0, inf/inf)
//  flag_dz    out  1   divide by zero (finite nonzero / zero)
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - state=IDLE; out_valid=0; result=0; flag_nv=0; flag_dz=0.
//   - Any in-flight division is abandoned, with no output.
//  States: IDLE -> (DIV -> RND) | (special case) -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - in_valid=1 latches a, b, sign=a[63]^b[63]. Next state is DONE for a special case, else DIV.
//  Subnormal operands (exp==0) are treated as signed zero.
//  Special cases, checked in priority order:
//   1. NaN in either operand -> 0x7FF8000000000000, nv=1.
//   2. inf/inf or 0/0 -> 0x7FF8000000000000, nv=1.
//   3. inf/x -> {sign, 0x7FF, 0}.
//   4. x/inf -> {sign, 0, 0}.
//   5. x/0 -> {sign, 0x7FF, 0}, dz=1.
//   6. 0/x -> {sign, 0, 0}.
//  DIV:
//   - Significands ma={1,frac_a} and mb={1,frac_b} (53b).
//   - Restoring division runs 55 cycles with a 6-bit down-counter (54..0).
//   - Yields q[54:0] = floor(ma*2^54/mb) and remainder rem (54b).
//   - exp_t = ea - eb + 1023, held as 13-bit signed.
//  RND (1 cycle), normalise:
//   - If q[54]=1: mant=q[54:2], g=q[1], s=q[0]|(rem!=0), e=exp_t.
//   - Else: mant=q[53:1], g=q[0], s=(rem!=0), e=exp_t-1.
//  RND, round:
//   - inc = g & (s | mant[0]).
//   - On carry out of 53 bits: mant >>= 1, e += 1.
//  RND, range:
//   - e >= 2047 -> {sign, 0x7FF, 0}.
//   - e <= 0 -> {sign, 0, 0} (flush, no subnormal output).
//   - Else -> {sign, e[10:0], mant[51:0]}.
//  DONE:
//   - out_valid=1.
//   - result and flags are stable while out_ready=0.
//   - out_ready=1 at an edge -> IDLE; out_valid=0 from the next cycle.
//  Latency from the accepting edge to out_valid=1:
//   - Normal: 57 edges (55 DIV + 1 RND + entry to DONE).
//   - Special case: 1 edge.
//  No new accept while busy or in DONE; in_ready is low outside IDLE.
//  in_valid asserted with in_ready=0 is ignored, and a/b are not sampled.
//  Flags are cleared at every accept.
// TESTING
//  1. a=0x4018000000000000 (6.0), b=0x4000000000000000 (2.0) -> result=0x4008000000000000, out_valid exactly 57 edges after accept.
//  2. a=0x3FF0000000000000, b=0x4008000000000000 (1/3) -> result=0x3FD5555555555555 (RNE rounds down), flags 0.
//  3. a=0x3FF0000000000000, b=0 -> 0x7FF0000000000000, dz=1, 1-edge latency; a=0, b=0 -> 0x7FF8000000000000, nv=1.
//  4. a=0x7FE0000000000000, b=0x3FE0000000000000 -> 0x7FF0000000000000 (overflow); a=0x0010000000000000, b=0x4000000000000000 -> 0 (underflow flush).
//  5. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, a new in_valid ignored; release -> IDLE next edge.
//  6. Assert rst during cycle 20 of DIV -> out_valid=0, result=0, in_ready=1 next cycle; a fresh 6.0/2.0 completes correctly.

Source files
------------

// File: rtl/fp_div_d.sv
// ---------------------------------------------------------------------------
// fp_div_d
//
// Iterative IEEE 754 double-precision divider, result = a / b, with
// round-to-nearest-even. It develops one quotient bit per clock using radix-2
// restoring division. Operands and results move through valid/ready
// handshakes.
//
// Number-format rules are the same as the companion double multiplier:
//   - A subnormal operand (exponent field 0) is treated as a signed zero.
//   - Every NaN result is the canonical 0x7FF8000000000000.
//   - Overflow saturates to a signed infinity.
//   - Underflow flushes to a signed zero. No subnormal result is produced.
//
// Ports
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   operands a/b valid
//   in_ready   out  1   idle and able to accept operands
//   a          in   64  dividend (double)
//   b          in   64  divisor (double)
//   out_valid  out  1   result valid, held until out_ready
//   out_ready  in   1   consumer accepts result
//   result     out  64  quotient (double)
//   flag_nv    out  1   invalid operation (NaN operand, 0/0, inf/inf)
//   flag_dz    out  1   divide by zero (finite nonzero / zero)
//
// Latency from the accepting edge to out_valid, counting the accepting edge
// as edge 1:
//   - normal operands: 57 edges
//   - special cases:   1 edge
// ---------------------------------------------------------------------------
module fp_div_d #(
    parameter int QBITS = 55
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        flag_nv,
    output logic        flag_dz
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_RND  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

    logic [1:0]       state_q, state_d;
    logic             sign_q,  sign_d;
    logic [12:0]      exp_q,   exp_d;
    logic [52:0]      mb_q,    mb_d;
    logic [53:0]      rem_q,   rem_d;
    logic [QBITS-1:0] quo_q,   quo_d;
    logic [5:0]       cnt_q,   cnt_d;
    logic [63:0]      result_q, result_d;
    logic             nv_q,    nv_d;
    logic             dz_q,    dz_d;

    // -----------------------------------------------------------------------
    // Operand classification
    // -----------------------------------------------------------------------
    logic [10:0] a_exp, b_exp;
    logic [51:0] a_frac, b_frac;
    logic        a_nan, a_inf, a_zero;
    logic        b_nan, b_inf, b_zero;
    logic        sign_in;

    always_comb begin
        a_exp   = a[62:52];
        b_exp   = b[62:52];
        a_frac  = a[51:0];
        b_frac  = b[51:0];
        a_nan   = (&a_exp) && (|a_frac);
        a_inf   = (&a_exp) && !(|a_frac);
        a_zero  = !(|a_exp);
        b_nan   = (&b_exp) && (|b_frac);
        b_inf   = (&b_exp) && !(|b_frac);
        b_zero  = !(|b_exp);
        sign_in = a[63] ^ b[63];
    end

    // -----------------------------------------------------------------------
    // Special-case results. The order of the checks sets their priority.
    // A subnormal operand already decodes as zero, so it falls into the
    // zero cases here.
    // -----------------------------------------------------------------------
    logic        spec_hit;
    logic [63:0] spec_res;
    logic        spec_nv;
    logic        spec_dz;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = 64'd0;
        spec_nv  = 1'b0;
        spec_dz  = 1'b0;
        if (a_nan || b_nan) begin
            spec_res = CANON_NAN;
            spec_nv  = 1'b1;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            spec_res = CANON_NAN;
            spec_nv  = 1'b1;
        end else if (a_inf) begin
            spec_res = {sign_in, 11'h7FF, 52'd0};
        end else if (b_inf) begin
            spec_res = {sign_in, 63'd0};
        end else if (b_zero) begin
            spec_res = {sign_in, 11'h7FF, 52'd0};
            spec_dz  = 1'b1;
        end else if (a_zero) begin
            spec_res = {sign_in, 63'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // One restoring division step.
    //
    // The partial remainder is always below 2*mb, so 54 bits are enough.
    // After a successful subtraction it is below mb, so the left shift never
    // loses a set bit. The final zero test on the remainder therefore stays
    // exact, even though the last step shifts as well.
    // -----------------------------------------------------------------------
    logic [54:0] trial;
    logic        q_bit;
    logic [53:0] rem_sel;
    logic [53:0] rem_shift;

    always_comb begin
        trial     = {1'b0, rem_q} - {2'b00, mb_q};
        q_bit     = !trial[54];
        rem_sel   = q_bit ? trial[53:0] : rem_q;
        rem_shift = rem_sel << 1;
    end

    // -----------------------------------------------------------------------
    // Normalise, round to nearest even, then range-check the result.
    //
    // The quotient lies in (0.5, 2) scaled by 2^54. When the top bit is
    // clear, the result needs one extra left shift and the exponent drops
    // by one.
    // -----------------------------------------------------------------------
    logic [52:0] mant;
    logic        guard_bit;
    logic        sticky_bit;
    logic        inc;
    logic [53:0] mant_sum;
    logic [12:0] e_pre;
    logic [12:0] e_rnd;
    logic [51:0] frac_rnd;
    logic [63:0] rnd_res;

    always_comb begin
        if (quo_q[QBITS-1]) begin
            mant       = quo_q[QBITS-1:QBITS-53];
            guard_bit  = quo_q[1];
            sticky_bit = quo_q[0] | (|rem_q);
            e_pre      = exp_q;
        end else begin
            mant       = quo_q[QBITS-2:QBITS-54];
            guard_bit  = quo_q[0];
            sticky_bit = |rem_q;
            e_pre      = exp_q - 13'd1;
        end

        inc      = guard_bit & (sticky_bit | mant[0]);
        mant_sum = {1'b0, mant} + {53'd0, inc};

        // A carry out of 53 bits leaves an exact power of two.
        if (mant_sum[53]) begin
            frac_rnd = mant_sum[52:1];
            e_rnd    = e_pre + 13'd1;
        end else begin
            frac_rnd = mant_sum[51:0];
            e_rnd    = e_pre;
        end

        if ($signed(e_rnd) >= 13'sd2047) begin
            rnd_res = {sign_q, 11'h7FF, 52'd0};
        end else if ($signed(e_rnd) <= 13'sd0) begin
            rnd_res = {sign_q, 63'd0};
        end else begin
            rnd_res = {sign_q, e_rnd[10:0], frac_rnd};
        end
    end

    // -----------------------------------------------------------------------
    // Control and datapath next-state logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mb_d     = mb_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        nv_d     = nv_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = sign_in;
                    nv_d   = 1'b0;
                    dz_d   = 1'b0;
                    if (spec_hit) begin
                        result_d = spec_res;
                        nv_d     = spec_nv;
                        dz_d     = spec_dz;
                        state_d  = S_DONE;
                    end else begin
                        // Biased exponent of the quotient. It is kept signed
                        // so that overflow and underflow remain visible
                        // until rounding.
                        exp_d   = {2'b00, a_exp} - {2'b00, b_exp} + 13'd1023;
                        mb_d    = {1'b1, b_frac};
                        rem_d   = {2'b01, a_frac};
                        quo_d   = '0;
                        cnt_d   = 6'd54;
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                quo_d = {quo_q[QBITS-2:0], q_bit};
                rem_d = rem_shift;
                if (cnt_q == 6'd0) begin
                    state_d = S_RND;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_RND: begin
                result_d = rnd_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers. A reset abandons any division in progress without
    // producing an output.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mb_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            nv_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mb_q     <= mb_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            nv_q     <= nv_d;
            dz_q     <= dz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flag_nv   = nv_q;
    assign flag_dz   = dz_q;

endmodule

// File: tb/tb_fp_div_d.sv
// ---------------------------------------------------------------------------
// tb_fp_div_d
//
// Self-checking bench for fp_div_d.
//
// Directed cases use hand-derived constants. Random operands are checked
// against a reference model built from the number-format rules. The model
// handles special operands explicitly. Ordinary quotients come from native
// double division, with subnormal results flushed to a signed zero.
// ---------------------------------------------------------------------------
module tb_fp_div_d;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        flag_nv;
    logic        flag_dz;

    int pass_count  = 0;
    int check_count = 0;

    // 100 MHz clock.
    always #5 clk = ~clk;

    fp_div_d dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_nv   (flag_nv),
        .flag_dz   (flag_dz)
    );

    // One comparison, counted and reported on failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Reference model: expected quotient, flags and whether the case is a
    // special one (1-edge latency).
    function automatic void refModel(input logic [63:0] x, input logic [63:0] y,
                                     output logic [63:0] res, output logic nv,
                                     output logic dz, output logic special);
        logic        sgn;
        logic        x_nan, x_inf, x_zero, y_nan, y_inf, y_zero;
        real         q;
        logic [63:0] bits;
        sgn    = x[63] ^ y[63];
        x_nan  = (x[62:52] == 11'h7FF) && (x[51:0] != 0);
        x_inf  = (x[62:52] == 11'h7FF) && (x[51:0] == 0);
        x_zero = (x[62:52] == 11'h000);
        y_nan  = (y[62:52] == 11'h7FF) && (y[51:0] != 0);
        y_inf  = (y[62:52] == 11'h7FF) && (y[51:0] == 0);
        y_zero = (y[62:52] == 11'h000);
        nv      = 1'b0;
        dz      = 1'b0;
        special = 1'b1;
        res     = 64'd0;
        if (x_nan || y_nan) begin
            res = 64'h7FF8_0000_0000_0000;
            nv  = 1'b1;
        end else if ((x_inf && y_inf) || (x_zero && y_zero)) begin
            res = 64'h7FF8_0000_0000_0000;
            nv  = 1'b1;
        end else if (x_inf) begin
            res = {sgn, 11'h7FF, 52'd0};
        end else if (y_inf) begin
            res = {sgn, 63'd0};
        end else if (y_zero) begin
            res = {sgn, 11'h7FF, 52'd0};
            dz  = 1'b1;
        end else if (x_zero) begin
            res = {sgn, 63'd0};
        end else begin
            special = 1'b0;
            q    = $bitstoreal({1'b0, x[62:0]}) / $bitstoreal({1'b0, y[62:0]});
            bits = $realtobits(q);
            if (bits[62:52] == 11'h000) res = {sgn, 63'd0};
            else                        res = {sgn, bits[62:0]};
        end
    endfunction

    // Random operand, biased toward normal values near unit exponent, with
    // zeros, subnormals, infinities, NaNs and extreme exponents mixed in.
    function automatic logic [63:0] genOperand();
        int          kind;
        logic        s;
        logic [10:0] e;
        logic [63:0] raw;
        logic [51:0] f;
        kind = int'($urandom_range(0, 15));
        s    = 1'($urandom_range(0, 1));
        raw  = {$urandom, $urandom};
        f    = raw[51:0];
        case (kind)
            0:       begin e = 11'h000; f = 52'd0; end
            1:       begin e = 11'h000; f[0] = 1'b1; end
            2:       begin e = 11'h7FF; f = 52'd0; end
            3:       begin e = 11'h7FF; f[0] = 1'b1; end
            4, 5:    e = 11'($urandom_range(1, 2046));
            default: e = 11'($urandom_range(723, 1323));
        endcase
        return {s, e, f};
    endfunction

    // Present one operand pair, then count edges from the accepting edge
    // (edge 1) until out_valid. The wait is bounded.
    task automatic applyStimulus(input logic [63:0] x, input logic [63:0] y,
                                 output int edges);
        int guard_cnt;
        guard_cnt = 0;
        while (!in_ready && guard_cnt < 100) begin
            @(posedge clk); #1;
            guard_cnt++;
        end
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        edges    = 1;
        while (!out_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // Accept the result and confirm the block returns to idle.
    task automatic releaseOutput(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, ".in_ready"},  64'(in_ready),  64'd1);
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    endtask

    task automatic runDirected(input string tag, input logic [63:0] x,
                               input logic [63:0] y, input logic [63:0] exp_res,
                               input logic exp_nv, input logic exp_dz,
                               input int exp_lat);
        int edges;
        applyStimulus(x, y, edges);
        checkOutput({tag, ".latency"}, 64'(edges),   64'(exp_lat));
        checkOutput({tag, ".result"},  result,       exp_res);
        checkOutput({tag, ".nv"},      64'(flag_nv), 64'(exp_nv));
        checkOutput({tag, ".dz"},      64'(flag_dz), 64'(exp_dz));
        releaseOutput(tag);
    endtask

    task automatic runRandom(input string tag, input logic [63:0] x,
                             input logic [63:0] y);
        logic [63:0] exp_res;
        logic        exp_nv, exp_dz, special;
        int          edges;
        refModel(x, y, exp_res, exp_nv, exp_dz, special);
        applyStimulus(x, y, edges);
        checkOutput({tag, ".latency"}, 64'(edges),   special ? 64'd1 : 64'd57);
        checkOutput({tag, ".result"},  result,       exp_res);
        checkOutput({tag, ".nv"},      64'(flag_nv), 64'(exp_nv));
        checkOutput({tag, ".dz"},      64'(flag_dz), 64'(exp_dz));
        releaseOutput(tag);
    endtask

    initial begin
        logic [63:0] held;
        int          edges;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 64'd0;
        b         = 64'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.in_ready",  64'(in_ready),  64'd1);
        checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset.result",    result,         64'd0);
        checkOutput("reset.nv",        64'(flag_nv),   64'd0);
        checkOutput("reset.dz",        64'(flag_dz),   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        runDirected("six_by_two", 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000,
                    64'h4008_0000_0000_0000, 1'b0, 1'b0, 57);
        runDirected("one_third", 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000,
                    64'h3FD5_5555_5555_5555, 1'b0, 1'b0, 57);
        runDirected("div_zero", 64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0000,
                    64'h7FF0_0000_0000_0000, 1'b0, 1'b1, 1);
        runDirected("zero_zero", 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000,
                    64'h7FF8_0000_0000_0000, 1'b1, 1'b0, 1);
        runDirected("overflow", 64'h7FE0_0000_0000_0000, 64'h3FE0_0000_0000_0000,
                    64'h7FF0_0000_0000_0000, 1'b0, 1'b0, 57);
        runDirected("underflow", 64'h0010_0000_0000_0000, 64'h4000_0000_0000_0000,
                    64'h0000_0000_0000_0000, 1'b0, 1'b0, 57);
        runDirected("neg_inf_by_x", 64'hFFF0_0000_0000_0000, 64'h4000_0000_0000_0000,
                    64'hFFF0_0000_0000_0000, 1'b0, 1'b0, 1);

        // Backpressure: the result stays stable and a new request is
        // ignored while the output is held.
        applyStimulus(64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, edges);
        checkOutput("bp.latency", 64'(edges), 64'd57);
        held = result;
        checkOutput("bp.result", held, 64'h3FD5_5555_5555_5555);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = 64'h4018_0000_0000_0000;
            b        = 64'h0000_0000_0000_0000;
            @(posedge clk); #1;
            checkOutput($sformatf("bp.hold%0d.result", i), result, 64'h3FD5_5555_5555_5555);
            checkOutput($sformatf("bp.hold%0d.in_ready", i), 64'(in_ready), 64'd0);
            checkOutput($sformatf("bp.hold%0d.out_valid", i), 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        checkOutput("bp.flag_dz", 64'(flag_dz), 64'd0);
        releaseOutput("bp.release");

        // Reset during cycle 20 of the division abandons it.
        a        = 64'h4018_0000_0000_0000;
        b        = 64'h4000_0000_0000_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst.out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst.result",    result,         64'd0);
        checkOutput("midrst.in_ready",  64'(in_ready),  64'd1);
        runDirected("after_rst", 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000,
                    64'h4008_0000_0000_0000, 1'b0, 1'b0, 57);

        // Random operands against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [63:0] x, y;
            x = genOperand();
            y = genOperand();
            runRandom($sformatf("rand%0d", n), x, y);
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
